// File: rtl/tc_mem_loader_pkg.sv
// tc_mem_loader_pkg: shared state type, TCM depth and lane-mask helper for the image loader
package tc_mem_loader_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERROR} state_t;
   localparam int DEPTH = 6144;
   function automatic logic [3:0] lane_mask(input logic [2:0] n_bytes);
      return 4'((5'd1 << n_bytes) - 5'd1);
   endfunction
endpackage

// File: rtl/tc_mem_image_loader_packer.sv
// byte_to_word_packer: assembles accepted bytes into little-endian words with a lane mask
module byte_to_word_packer
   import tc_mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_clr,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   input  logic        i_eop,
   output logic [31:0] o_word,
   output logic [3:0]  o_be,
   output logic        o_word_valid
);
   logic [1:0]  r_idx;
   logic [31:0] r_asm;
   assign o_word       = r_asm | (32'(i_data) << {r_idx, 3'b000});
   assign o_be         = lane_mask(3'(r_idx) + 3'd1);
   assign o_word_valid = i_valid & ((r_idx == 2'd3) | i_eop);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_idx <= '0;
         r_asm <= '0;
      end else if (i_clr || o_word_valid) begin
         r_idx <= '0;
         r_asm <= '0;
      end else if (i_valid) begin
         r_idx <= r_idx + 2'd1;
         r_asm <= o_word;
      end
endmodule

// File: rtl/tc_mem_image_loader.sv
// tc_mem_image_loader: streams a byte image into TCM port 2 as sequential little-endian words
module tc_mem_image_loader #(
   parameter int ADDR_W = 13,
   parameter int DEPTH  = tc_mem_loader_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              sink_valid,
   output logic              sink_ready,
   input  logic [7:0]        sink_data,
   input  logic              sink_eop,
   output logic [ADDR_W-1:0] address2,
   output logic [3:0]        byteenable2,
   output logic              chipselect2,
   output logic              write2,
   output logic [31:0]       writedata2,
   output logic              clken2,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count,
   output logic [31:0]       checksum
);
   import tc_mem_loader_pkg::*;
   localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
   state_t            r_state, w_next;
   logic              r_flush, w_flush;
   logic [ADDR_W-1:0] r_base, r_addr;
   logic [ADDR_W:0]   r_wc, w_fill;
   logic [31:0]       r_sum, r_data, w_word;
   logic [3:0]        r_be, w_be;
   logic              r_wr, w_acc, w_full, w_start, w_bad_base, w_pk_valid, w_wdone;
   assign w_acc      = sink_valid & sink_ready;
   assign w_fill     = {1'b0, r_base} + r_wc;
   assign w_full     = w_fill >= L_DEPTH;
   assign w_bad_base = {1'b0, base_addr} >= L_DEPTH;
   assign w_start    = start & ~abort & (r_state inside {S_IDLE, S_DONE, S_ERROR});
   assign w_pk_valid = w_acc & (r_state == S_LOAD) & ~w_full & ~abort;
   byte_to_word_packer u_packer (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_clr       (abort | w_start),
      .i_valid     (w_pk_valid),
      .i_data      (sink_data),
      .i_eop       (sink_eop),
      .o_word      (w_word),
      .o_be        (w_be),
      .o_word_valid(w_wdone)
   );
   // r_flush keeps ERROR draining the stream until the image's EOP has gone by
   always_comb begin
      w_next  = r_state;
      w_flush = r_flush;
      if (abort) begin
         w_next  = S_IDLE;
         w_flush = 1'b0;
      end else if (w_start) begin
         w_next  = w_bad_base ? S_ERROR : S_LOAD;
         w_flush = w_bad_base;
      end else if (r_state == S_LOAD && w_acc) begin
         w_next  = w_full ? S_ERROR : (sink_eop ? S_DRAIN : S_LOAD);
         w_flush = w_full & ~sink_eop;
      end else if (r_state == S_DRAIN) begin
         w_next = S_DONE;
      end else if (r_state == S_ERROR && w_acc && sink_eop) begin
         w_flush = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_flush <= 1'b0;
         r_base  <= '0;
         r_wc    <= '0;
         r_sum   <= '0;
         r_addr  <= '0;
         r_be    <= '0;
         r_data  <= '0;
         r_wr    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_flush <= w_flush;
         r_wr    <= w_wdone;
         if (w_start) begin
            r_base <= base_addr;
            r_wc   <= '0;
            r_sum  <= '0;
         end
         if (w_wdone) begin
            r_addr <= r_base + r_wc[ADDR_W-1:0];
            r_be   <= w_be;
            r_data <= w_word;
            r_wc   <= r_wc + 1'b1;
            r_sum  <= r_sum + w_word;
         end
      end
   assign sink_ready  = (r_state == S_LOAD) | ((r_state == S_ERROR) & r_flush);
   assign address2    = r_addr;
   assign byteenable2 = r_be;
   assign writedata2  = r_data;
   assign write2      = r_wr;
   assign chipselect2 = r_wr;
   assign clken2      = 1'b1;
   assign busy        = (r_state == S_LOAD) | (r_state == S_DRAIN);
   assign done        = r_state == S_DONE;
   assign error       = r_state == S_ERROR;
   assign word_count  = r_wc;
   assign checksum    = r_sum;
endmodule

// File: tb/tb_tc_mem_image_loader.sv
// tb_tc_mem_image_loader: directed self-checking bench for the TCM image loader
module tb_tc_mem_image_loader;
   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic        sink_valid = 1'b0, sink_eop = 1'b0;
   logic [12:0] base_addr = '0;
   logic [7:0]  sink_data = '0;
   logic        sink_ready, chipselect2, write2, clken2, busy, done, error;
   logic [12:0] address2;
   logic [3:0]  byteenable2;
   logic [31:0] writedata2, checksum;
   logic [13:0] word_count;
   logic [12:0] q_addr[$];
   logic [31:0] q_data[$];
   logic [3:0]  q_be[$];
   int n_checks = 0, n_errors = 0;
   always #5 clk = ~clk;
   tc_mem_image_loader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base_addr(base_addr),
      .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data), .sink_eop(sink_eop),
      .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .write2(write2),
      .writedata2(writedata2), .clken2(clken2), .busy(busy), .done(done), .error(error),
      .word_count(word_count), .checksum(checksum)
   );
   always @(negedge clk)
      if (write2) begin
         q_addr.push_back(address2);
         q_data.push_back(writedata2);
         q_be.push_back(byteenable2);
      end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic chk_wr(input int i, input logic [12:0] a, input logic [31:0] d, input logic [3:0] b);
      logic [48:0] obs;
      obs = (i < q_addr.size()) ? {q_addr[i], q_data[i], q_be[i]} : 'x;
      chk($sformatf("write%0d addr/data/be", i), 64'(obs), 64'({a, d, b}));
   endtask
   task automatic clr_log();
      q_addr.delete();
      q_data.delete();
      q_be.delete();
   endtask
   task automatic send(input logic [7:0] d, input logic e);
      sink_valid = 1'b1;
      sink_data  = d;
      sink_eop   = e;
      tick();
      sink_valid = 1'b0;
      sink_eop   = 1'b0;
   endtask
   task automatic go(input logic [12:0] b);
      base_addr = b;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask
   initial begin
      #20;
      chk("reset outputs", {write2, chipselect2, busy, done, error, sink_ready}, 6'b0);
      chk("reset addr/be/data", {address2, byteenable2, writedata2}, '0);
      chk("reset count/sum", {word_count, checksum}, '0);
      chk("clken2", clken2, 1'b1);
      #2 reset_n = 1'b1;
      tick();
      // aligned load with a valid gap and an ignored mid-load start
      go(13'h100);
      chk("load busy/ready", {busy, sink_ready}, 2'b11);
      send(8'h01, 0); send(8'h02, 0); tick(); send(8'h03, 0);
      start = 1'b1; base_addr = 13'h0;
      send(8'h04, 0);
      start = 1'b0;
      chk("word0 issue", {write2, chipselect2, address2}, {2'b11, 13'h100});
      chk("word0 count", word_count, 14'd1);
      send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
      chk("eop drain", {busy, sink_ready, write2}, 3'b101);
      chk("aligned count", word_count, 14'd2);
      chk("aligned checksum", checksum, 32'h0C0A0806);
      tick();
      chk("aligned done", {done, busy, write2}, 3'b100);
      chk("aligned nwrites", q_addr.size(), 2);
      chk_wr(0, 13'h100, 32'h04030201, 4'hF);
      chk_wr(1, 13'h101, 32'h08070605, 4'hF);
      // partial final word
      clr_log();
      go(13'h0);
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 1);
      tick();
      chk("partial done", done, 1'b1);
      chk("partial count/sum", {word_count, checksum}, {14'd2, 32'hDDCCBC98});
      chk("partial hold", {write2, address2, byteenable2, writedata2}, {1'b0, 13'd1, 4'b0001, 32'h000000EE});
      chk("partial nwrites", q_addr.size(), 2);
      chk_wr(0, 13'd0, 32'hDDCCBBAA, 4'hF);
      chk_wr(1, 13'd1, 32'h000000EE, 4'b0001);
      // overflow at the top of memory
      clr_log();
      go(13'd6143);
      send(8'h11, 0); send(8'h12, 0); send(8'h13, 0); send(8'h14, 0);
      chk("ovf last write", {write2, address2}, {1'b1, 13'd6143});
      send(8'h15, 0);
      chk("ovf error", {error, busy, sink_ready, write2}, 4'b1010);
      send(8'h16, 0); send(8'h17, 0);
      chk("ovf ready flush", sink_ready, 1'b1);
      send(8'h18, 1);
      chk("ovf after eop", {error, sink_ready}, 2'b10);
      chk("ovf count/sum", {word_count, checksum}, {14'd1, 32'h14131211});
      chk("ovf nwrites", q_addr.size(), 1);
      chk_wr(0, 13'd6143, 32'h14131211, 4'hF);
      // bad base
      clr_log();
      go(13'd6144);
      chk("badbase error", {error, busy, sink_ready}, 3'b101);
      chk("badbase count", word_count, 14'd0);
      send(8'h55, 1);
      chk("badbase flushed", {error, sink_ready}, 2'b10);
      chk("badbase nwrites", q_addr.size(), 0);
      // abort then restart from lane 0
      go(13'h10);
      send(8'h21, 0); send(8'h22, 0); send(8'h23, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort idle", {busy, done, error, write2, sink_ready}, 5'b0);
      tick();
      chk("abort nwrites", q_addr.size(), 0);
      go(13'h20);
      send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h34, 1);
      chk("restart write", {write2, address2, writedata2}, {1'b1, 13'h20, 32'h34333231});
      tick();
      chk("restart done", done, 1'b1);
      chk("restart nwrites", q_addr.size(), 1);
      // async reset while a write is on the port
      go(13'h40);
      send(8'h41, 0); send(8'h42, 0); send(8'h43, 0); send(8'h44, 0);
      chk("pre-reset write", write2, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset ctrl", {write2, chipselect2, busy, done, error, sink_ready}, 6'b0);
      chk("async reset port", {address2, byteenable2, writedata2}, '0);
      chk("async reset status", {word_count, checksum}, '0);
      @(negedge clk) reset_n = 1'b1;
      tick();
      chk("post-reset idle", {busy, done, error, sink_ready}, 4'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/tc_mem_image_loader.md
# tc_mem_image_loader

Fills the PCP tightly-coupled memory through its second (s2) port from a byte-wide Avalon-ST stream carrying a firmware or descriptor image. It sits directly upstream of the dual-port TCM and drives its port-2 write signals. The block assembles bytes into little-endian 32-bit words, writes them sequentially from a programmable base word address, and reports a running 32-bit word checksum and a completion or error status to the controlling CPU.

## Interface
- `ADDR_W`, 13: TCM word-address width.
- `DEPTH`, 6144: number of TCM words; the highest writable address is DEPTH-1.
- `clk`, in, 1: single clock, shared with the TCM port-2 clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle pulse; arms a load. Honoured only in IDLE, DONE or ERROR.
- `abort`, in, 1: returns the block to IDLE from any state; takes priority over everything else.
- `base_addr`, in, ADDR_W: first word address, sampled on `start`.
- `sink_valid`, in, 1: Avalon-ST valid.
- `sink_ready`, out, 1: Avalon-ST ready.
- `sink_data`, in, 8: image byte.
- `sink_eop`, in, 1: marks the last byte of the image.
- `address2`, out, ADDR_W: TCM write address.
- `byteenable2`, out, 4: TCM byte lanes.
- `chipselect2`, out, 1: TCM chip select.
- `write2`, out, 1: TCM write strobe.
- `writedata2`, out, 32: TCM write data.
- `clken2`, out, 1: constant 1.
- `busy`, out, 1: high in LOAD or DRAIN.
- `done`, out, 1: high in DONE.
- `error`, out, 1: high in ERROR.
- `word_count`, out, ADDR_W+1: number of words written in this load.
- `checksum`, out, 32: mod-2^32 sum of the written words, with disabled byte lanes counted as 0.

## Operation
- States: IDLE, LOAD, DRAIN, DONE, ERROR.
- **IDLE / DONE / ERROR + `start`:**
  - Go to LOAD.
  - Latch `base_addr`.
  - Clear `word_count`, `checksum`, the lane index and the assembly register.
  - If `base_addr` ≥ DEPTH, go to ERROR instead.
- **LOAD:**
  - `sink_ready` = 1. A byte is accepted when valid & ready.
  - The byte goes to lane `idx` (byte 0 goes to bits 7:0), and `idx` increments.
- **Word completion:** when the accepted byte has `idx` = 3 or `sink_eop` = 1, register a write for the next cycle:
  - `writedata2` = the assembled word.
  - `byteenable2` = the lanes received (for example 4'b0011 after 2 bytes).
  - `address2` = base + `word_count`.
  - `chipselect2` = `write2` = 1 for exactly one cycle.
  - In the same cycle, increment `word_count`, add to `checksum`, and reset `idx` to 0.
- **Accepting `sink_eop`:** go to DRAIN, which deasserts `sink_ready`. The following cycle goes to DONE once the final write has issued.
- **Overflow:** if a word completes while `word_count` + base = DEPTH, suppress the write and go to ERROR. A non-EOP byte accepted after the last in-range word has been written is discarded, and the block goes to ERROR.
- **ERROR:** `sink_ready` = 1, and bytes are consumed and discarded until `sink_eop`, so the stream is not stalled. The block then stays in ERROR. `word_count` and `checksum` keep the values from the last good write.
- **Write data:** unwritten lanes of `writedata2` are 0.
- **Idle port:** `write2` = `chipselect2` = 0 whenever no write is issued. `address2`, `writedata2` and `byteenable2` hold their last values.
- **`abort`:** on the next edge go to IDLE, cancel any pending write, and clear `idx`. Memory contents already written stay as they are.
- **Address range:** the address never wraps. Exceeding DEPTH is always reported as ERROR.

## Timing
- **Reset values:**
  - state IDLE; `sink_ready` 0.
  - `address2`, `byteenable2`, `writedata2`: 0.
  - `chipselect2`, `write2`: 0.
  - `busy`, `done`, `error`: 0.
  - `word_count`, `checksum`: 0.
- **Write latency:** one cycle from the completing byte handshake to `write2` high.
- **Throughput:** 1 byte per cycle sustained; no back-pressure inside LOAD.
- **Status updates:** `word_count` and `checksum` update in the same cycle `write2` is high.
- **Completion:** `done` rises 2 cycles after the EOP handshake.
- **Event priority:** `abort` > overflow > eop > normal byte. A `start` arriving during LOAD or DRAIN is ignored.

## Structure
- Shared package `tc_mem_loader_pkg`: the state enum, `DEPTH`, and the lane-mask function (byte count to byteenable).
- One natural sub-module, `byte_to_word_packer`: the lane index, assembly register, byteenable and word-valid pulse. The FSM, address, count and checksum stay in the top level.

## Test plan
- **Aligned load:** base 0x100, 8 bytes 01..08 with eop on 08 → writes 0x04030201@0x100 and 0x08070605@0x101, both be=F. Then `done`, `word_count` = 2, `checksum` = 0x0C0A0806.
- **Partial final word:** base 0, 5 bytes AA BB CC DD EE (eop on EE) → second write 0x000000EE@1 with be=4'b0001, then `done`.
- **Overflow:** base 6143, 8 bytes → one write at 6143, then ERROR with no write at 6144. `sink_ready` stays high until eop, `word_count` = 1.
- **Bad base:** start with base 6144 → immediate ERROR, no writes.
- **Abort:** abort after 3 bytes → IDLE next cycle, no write issued. A restart then begins at lane 0.
- **Reset:** `reset_n` low mid-LOAD with `write2` high → all outputs 0 asynchronously, state IDLE; `valid` gaps between bytes do not affect the results of the other tests.
